mem_access_stage: RTL and testbench

- MEM stage of the RV32I pipeline, directly downstream of the EX-stage ALU.
- Consumes the registered ALU result as the load/store address, or passes it through for non-memory ops.
- Drives a req/ack data-memory port with byte enables, and returns aligned, sign/zero-extended load data to write-back.
- Stalls the upstream pipeline while a memory access is outstanding, and flags misaligned, illegal or timed-out accesses.

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/lsu_align.sv | 96 +++++++++
 rtl/mem_access_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the MEM stage: funct3 encodings,
// fault cause codes and the MEM FSM state encoding.
package rv32_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Reasons an instruction retires with a fault instead of a result
  typedef enum logic [1:0] {
    CAUSE_MISALIGNED = 2'd0,
    CAUSE_ILLEGAL    = 2'd1,
    CAUSE_TIMEOUT    = 2'd2
  } fault_cause_e;

  // MEM stage FSM: IDLE accepts instructions, ACCESS waits for dmem_ack
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port. The MEM stage is the master,
// the memory (or its model) is the slave.
interface mem_access_stage_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment helper for the MEM stage:
// formats store byte enables and lane-replicated data, detects illegal
// and misaligned requests, and extracts/extends load data from a word.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  req_funct3_i,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_offset_i,
  input  logic [31:0] req_rs2_i,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  output logic        req_illegal_o,
  output logic        req_misaligned_o,

  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [3:0] size_mask;
  logic [3:0] store_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and store data. Stores place their enables on the
  // addressed lanes; loads request a size-only mask and the wanted lane
  // is picked out of the returned word by the byte offset instead.
  always_comb begin
    size_mask   = 4'b1111;
    store_be    = 4'b1111;
    req_wdata_o = req_rs2_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        size_mask   = 4'b0001;
        store_be    = 4'b0001 << req_offset_i;
        req_wdata_o = {4{req_rs2_i[7:0]}};
      end
      2'b01: begin
        size_mask   = 4'b0011;
        store_be    = req_offset_i[1] ? 4'b1100 : 4'b0011;
        req_wdata_o = {2{req_rs2_i[15:0]}};
      end
      default: begin
        size_mask   = 4'b1111;
        store_be    = 4'b1111;
        req_wdata_o = req_rs2_i;
      end
    endcase
    req_be_o = req_write_i ? store_be : size_mask;
  end

  // Legality: a request cannot both read and write, loads only know
  // B/H/W/BU/HU and stores only B/H/W. Alignment is only judged for
  // otherwise legal requests so an illegal op never reports misaligned.
  always_comb begin
    req_illegal_o    = 1'b0;
    req_misaligned_o = 1'b0;
    if (req_read_i && req_write_i) begin
      req_illegal_o = 1'b1;
    end else if (req_read_i) begin
      req_illegal_o = (req_funct3_i == 3'd3) || (req_funct3_i == 3'd6) ||
                      (req_funct3_i == 3'd7);
    end else if (req_write_i) begin
      req_illegal_o = (req_funct3_i > F3_SW);
    end
    if (!req_illegal_o) begin
      case (req_funct3_i[1:0])
        2'b01:   req_misaligned_o = req_offset_i[0];
        2'b10:   req_misaligned_o = (req_offset_i != 2'b00);
        default: req_misaligned_o = 1'b0;
      endcase
    end
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    case (ld_offset_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_offset_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data_o = {24'h000000, ld_byte};
      F3_LHU:  ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: passes ALU results through, performs loads/stores
// over a req/ack data-memory port, stalls upstream while an access is
// outstanding and retires faulting ops with a one-cycle fault pulse.
module mem_access_stage
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                in_valid_i,
  input  logic [XLEN-1:0]     in_alu_result_i,
  input  logic [XLEN-1:0]     in_rs2_data_i,
  input  logic [2:0]          in_funct3_i,
  input  logic                in_mem_read_i,
  input  logic                in_mem_write_i,
  input  logic [4:0]          in_rd_i,
  input  logic                in_reg_write_i,
  output logic                stall_o,

  mem_access_stage_if.master  dmem,

  output logic                wb_valid_o,
  output logic [4:0]          wb_rd_o,
  output logic                wb_reg_write_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                fault_o,
  output logic [1:0]          fault_cause_o,
  output logic [XLEN-1:0]     fault_addr_o
);

  mem_state_e   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [16:0]  cnt_inc;

  logic [31:0]  addr_q, addr_d;
  logic         we_q, we_d;
  logic [3:0]   be_q, be_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [4:0]   rd_q, rd_d;
  logic         reg_write_q, reg_write_d;

  logic         wb_valid_q, wb_valid_d;
  logic [4:0]   wb_rd_q, wb_rd_d;
  logic         wb_reg_write_q, wb_reg_write_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic         fault_q, fault_d;
  fault_cause_e fault_cause_q, fault_cause_d;
  logic [31:0]  fault_addr_q, fault_addr_d;

  logic [3:0]   req_be;
  logic [31:0]  req_wdata;
  logic         req_illegal;
  logic         req_misaligned;
  logic [31:0]  ld_data;

  lsu_align u_align (
    .req_funct3_i     (in_funct3_i),
    .req_read_i       (in_mem_read_i),
    .req_write_i      (in_mem_write_i),
    .req_offset_i     (in_alu_result_i[1:0]),
    .req_rs2_i        (in_rs2_data_i),
    .req_be_o         (req_be),
    .req_wdata_o      (req_wdata),
    .req_illegal_o    (req_illegal),
    .req_misaligned_o (req_misaligned),
    .ld_funct3_i      (funct3_q),
    .ld_offset_i      (addr_q[1:0]),
    .ld_rdata_i       (dmem.rdata),
    .ld_data_o        (ld_data)
  );

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  // Next-state logic: IDLE samples the EX bundle and either retires it
  // at once (pass-through or fault) or latches it and starts an access;
  // ACCESS waits for ack or gives up after TIMEOUT_CYCLES quiet cycles.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    we_d           = we_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_data_d      = wb_data_q;
    fault_d        = 1'b0;
    fault_cause_d  = fault_cause_q;
    fault_addr_d   = fault_addr_q;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (in_valid_i) begin
          if (!in_mem_read_i && !in_mem_write_i) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = in_rd_i;
            wb_reg_write_d = in_reg_write_i;
            wb_data_d      = in_alu_result_i;
          end else if (req_illegal || req_misaligned) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = in_rd_i;
            wb_reg_write_d = 1'b0;
            fault_d        = 1'b1;
            fault_cause_d  = req_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
            fault_addr_d   = in_alu_result_i;
          end else begin
            state_d     = ACCESS;
            addr_d      = in_alu_result_i;
            we_d        = in_mem_write_i;
            be_d        = req_be;
            wdata_d     = req_wdata;
            funct3_d    = in_funct3_i;
            rd_d        = in_rd_i;
            reg_write_d = in_reg_write_i;
          end
        end
      end
      ACCESS: begin
        if (dmem.ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (we_q) begin
            wb_reg_write_d = 1'b0;
          end else begin
            wb_reg_write_d = reg_write_q;
            wb_data_d      = ld_data;
          end
        end else if (cnt_inc == 17'(TIMEOUT_CYCLES)) begin
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = 1'b0;
          fault_d        = 1'b1;
          fault_cause_d  = CAUSE_TIMEOUT;
          fault_addr_d   = addr_q;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and write-back registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      addr_q         <= 32'd0;
      we_q           <= 1'b0;
      be_q           <= 4'd0;
      wdata_q        <= 32'd0;
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      reg_write_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= 32'd0;
      fault_q        <= 1'b0;
      fault_cause_q  <= CAUSE_MISALIGNED;
      fault_addr_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      fault_q        <= fault_d;
      fault_cause_q  <= fault_cause_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  // The request is live exactly while the FSM sits in ACCESS, so it drops
  // the cycle after ack, timeout or reset.
  assign stall_o     = (state_q == ACCESS);
  assign dmem.req    = (state_q == ACCESS);
  assign dmem.we     = we_q;
  assign dmem.addr   = {addr_q[31:2], 2'b00};
  assign dmem.be     = be_q;
  assign dmem.wdata  = wdata_q;

  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_data_o      = wb_data_q;
  assign fault_o        = fault_q;
  assign fault_cause_o  = fault_cause_q;
  assign fault_addr_o   = fault_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for the MEM stage: a scoreboard queue holds the
// expected retirement of every instruction and a negedge monitor pops
// and compares it whenever the stage retires something.
module tb_mem_access_stage;
  import rv32_pkg::*;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic        regWrite;
    logic        checkData;
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] faultAddr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int   vectorCount = 0;
  int   missCount   = 0;
  logic monitorOn   = 1'b0;
  exp_t sbQueue[$];

  mem_access_stage_if dmemIf ();

  mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid),
    .in_alu_result_i (in_alu_result),
    .in_rs2_data_i   (in_rs2_data),
    .in_funct3_i     (in_funct3),
    .in_mem_read_i   (in_mem_read),
    .in_mem_write_i  (in_mem_write),
    .in_rd_i         (in_rd),
    .in_reg_write_i  (in_reg_write),
    .stall_o         (stall),
    .dmem            (dmemIf),
    .wb_valid_o      (wb_valid),
    .wb_rd_o         (wb_rd),
    .wb_reg_write_o  (wb_reg_write),
    .wb_data_o       (wb_data),
    .fault_o         (fault),
    .fault_cause_o   (fault_cause),
    .fault_addr_o    (fault_addr)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one EX bundle and let the next rising edge sample it
  task automatic applyStimulus(input logic valid, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [2:0] f3,
                               input logic [4:0] rd, input logic mr,
                               input logic mw, input logic rw);
    in_valid      = valid;
    in_alu_result = alu;
    in_rs2_data   = rs2;
    in_funct3     = f3;
    in_rd         = rd;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_reg_write  = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    in_valid      = 1'b0;
    in_alu_result = $urandom;
    in_rs2_data   = $urandom;
    in_funct3     = 3'($urandom_range(0, 7));
    in_rd         = 5'($urandom_range(0, 31));
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_reg_write  = 1'b0;
  endtask

  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> (8 * off);
    case (f3)
      3'd0:    return {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    return {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    return shifted & 32'h0000_00FF;
      3'd5:    return shifted & 32'h0000_FFFF;
      default: return rdata;
    endcase
  endfunction

  task automatic pushExp(input logic [4:0] rd, input logic rw, input logic chk,
                         input logic [31:0] data, input logic flt,
                         input logic [1:0] cause, input logic [31:0] faddr);
    exp_t e;
    e.rd = rd; e.regWrite = rw; e.checkData = chk; e.data = data;
    e.fault = flt; e.cause = cause; e.faultAddr = faddr;
    sbQueue.push_back(e);
  endtask

  // Full memory op: accept, check the held request, ack after ackAt
  // ACCESS cycles, then check the stall count and release timing.
  task automatic runMemOp(input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic isStore,
                          input logic [4:0] rd, input int ackAt,
                          input logic [31:0] rdata, input logic [3:0] expBe,
                          input logic [31:0] expWdata);
    int stallCount;
    pushExp(rd, !isStore, !isStore, loadModel(f3, addr[1:0], rdata), 1'b0, 2'd0, 32'd0);
    applyStimulus(1'b1, addr, rs2, f3, rd, !isStore, isStore, 1'b1);
    setIdle();
    checkOutput("mem_req_start", 32'(dmemIf.req), 32'd1);
    checkOutput("mem_we", 32'(dmemIf.we), 32'(isStore));
    if (isStore) checkOutput("mem_wdata", dmemIf.wdata, expWdata);
    stallCount = 0;
    for (int c = 1; c <= ackAt; c++) begin
      checkOutput("mem_addr_held", dmemIf.addr, {addr[31:2], 2'b00});
      checkOutput("mem_be_held", 32'(dmemIf.be), 32'(expBe));
      if (c == ackAt) begin
        dmemIf.ack   = 1'b1;
        dmemIf.rdata = rdata;
      end
      if (stall) stallCount++;
      @(posedge clk);
      #1;
      dmemIf.ack   = 1'b0;
      dmemIf.rdata = $urandom;
    end
    checkOutput("mem_stall_cycles", 32'(stallCount), 32'(ackAt));
    checkOutput("mem_req_dropped", 32'(dmemIf.req), 32'd0);
    checkOutput("mem_wb_timing", 32'(wb_valid), 32'd1);
  endtask

  // Scoreboard monitor: every retirement must match the oldest expectation
  always @(negedge clk) begin
    if (monitorOn && (wb_valid || fault)) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_retire", {30'd0, fault, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
        checkOutput("sb_wb_reg_write", 32'(wb_reg_write), 32'(e.regWrite));
        if (e.checkData) checkOutput("sb_wb_data", wb_data, e.data);
        checkOutput("sb_fault", 32'(fault), 32'(e.fault));
        if (e.fault) begin
          checkOutput("sb_fault_cause", 32'(fault_cause), 32'(e.cause));
          checkOutput("sb_fault_addr", fault_addr, e.faultAddr);
        end
      end
    end
  end

  initial begin
    logic [2:0] f3Pick [5];
    f3Pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    dmemIf.ack   = 1'b0;
    dmemIf.rdata = 32'd0;
    setIdle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_req", 32'(dmemIf.req), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_dmem_addr", dmemIf.addr, 32'd0);
    checkOutput("rst_dmem_be", 32'(dmemIf.be), 32'd0);
    monitorOn = 1'b1;

    // ALU pass-through, back-to-back with latency 1
    for (int i = 0; i < 4; i++) begin
      pushExp(5'(5 + i), 1'b1, 1'b1, 32'h0000_1234 + 32'(i * 3), 1'b0, 2'd0, 32'd0);
      applyStimulus(1'b1, 32'h0000_1234 + 32'(i * 3), $urandom, 3'($urandom_range(0, 7)),
                    5'(5 + i), 1'b0, 1'b0, 1'b1);
      checkOutput("pt_stall", 32'(stall), 32'd0);
      checkOutput("pt_latency", 32'(wb_valid), 32'd1);
    end
    setIdle();
    @(posedge clk);
    #1;
    checkOutput("idle_no_wb", 32'(wb_valid), 32'd0);

    // Loads with fixed vectors
    runMemOp(32'h0000_0103, 32'd0, F3_LB,  1'b0, 5'd10, 3, 32'h80FF_FFFF, 4'b0001, 32'd0);
    runMemOp(32'h0000_0103, 32'd0, F3_LBU, 1'b0, 5'd11, 3, 32'h80FF_FFFF, 4'b0001, 32'd0);
    runMemOp(32'h0000_0106, 32'd0, F3_LH,  1'b0, 5'd12, 1, 32'h8001_7FFF, 4'b0011, 32'd0);
    runMemOp(32'h0000_0106, 32'd0, F3_LHU, 1'b0, 5'd13, 2, 32'h8001_7FFF, 4'b0011, 32'd0);
    runMemOp(32'h0000_010C, 32'd0, F3_LW,  1'b0, 5'd14, 2, 32'hCAFE_F00D, 4'b1111, 32'd0);

    // Stores
    runMemOp(32'h0000_0202, 32'hAAAA_BEEF, F3_SH, 1'b1, 5'd15, 2, 32'd0, 4'b1100, 32'hBEEF_BEEF);
    runMemOp(32'h0000_0209, 32'h1122_3344, F3_SB, 1'b1, 5'd16, 1, 32'd0, 4'b0010, 32'h4444_4444);
    runMemOp(32'h0000_0708, 32'h1234_5678, F3_SW, 1'b1, 5'd17, 3, 32'd0, 4'b1111, 32'h1234_5678);

    // Randomised aligned loads
    for (int i = 0; i < 4; i++) begin
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [3:0]  be;
      f3  = f3Pick[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      be  = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
      runMemOp(32'h0000_0800 + 32'(i * 16) + 32'(off), 32'd0, f3, 1'b0, 5'(20 + i),
               $urandom_range(1, 3), $urandom, be, 32'd0);
    end

    // Misaligned and illegal ops retire immediately with a fault
    pushExp(5'd3, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 32'h0000_0301);
    applyStimulus(1'b1, 32'h0000_0301, 32'd0, F3_LW, 5'd3, 1'b1, 1'b0, 1'b1);
    checkOutput("mis_lw_no_req", 32'(dmemIf.req), 32'd0);
    checkOutput("mis_lw_stall", 32'(stall), 32'd0);
    pushExp(5'd4, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 32'h0000_0401);
    applyStimulus(1'b1, 32'h0000_0401, 32'd0, F3_LH, 5'd4, 1'b1, 1'b0, 1'b1);
    pushExp(5'd6, 1'b0, 1'b0, 32'd0, 1'b1, 2'd0, 32'h0000_0403);
    applyStimulus(1'b1, 32'h0000_0403, 32'd0, F3_SH, 5'd6, 1'b0, 1'b1, 1'b0);
    pushExp(5'd7, 1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'h0000_0410);
    applyStimulus(1'b1, 32'h0000_0410, 32'd0, F3_LW, 5'd7, 1'b1, 1'b1, 1'b1);
    pushExp(5'd8, 1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'h0000_0420);
    applyStimulus(1'b1, 32'h0000_0420, 32'd0, 3'd3, 5'd8, 1'b1, 1'b0, 1'b1);
    pushExp(5'd9, 1'b0, 1'b0, 32'd0, 1'b1, 2'd1, 32'h0000_0431);
    applyStimulus(1'b1, 32'h0000_0431, 32'd0, 3'd4, 5'd9, 1'b0, 1'b1, 1'b0);
    checkOutput("illegal_no_req", 32'(dmemIf.req), 32'd0);
    setIdle();
    @(posedge clk);
    #1;

    // Timeout: request held for TIMEOUT ACCESS cycles, then cause 2
    pushExp(5'd18, 1'b0, 1'b0, 32'd0, 1'b1, 2'd2, 32'h0000_0502);
    applyStimulus(1'b1, 32'h0000_0502, 32'd0, F3_LH, 5'd18, 1'b1, 1'b0, 1'b1);
    setIdle();
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput("to_req_held", 32'(dmemIf.req), 32'd1);
      @(posedge clk);
      #1;
    end
    checkOutput("to_req_dropped", 32'(dmemIf.req), 32'd0);
    checkOutput("to_stall", 32'(stall), 32'd0);
    checkOutput("to_fault", 32'(fault), 32'd1);

    // Reset in the middle of an access; the stale ack must be ignored
    applyStimulus(1'b1, 32'h0000_0600, 32'd0, F3_LW, 5'd19, 1'b1, 1'b0, 1'b1);
    setIdle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mrst_req", 32'(dmemIf.req), 32'd0);
    checkOutput("mrst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    dmemIf.ack   = 1'b1;
    dmemIf.rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    dmemIf.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("mrst_no_wb", 32'(wb_valid), 32'd0);
      checkOutput("mrst_no_fault", 32'(fault), 32'd0);
      @(posedge clk);
      #1;
    end

    // Stage keeps working after the reset
    pushExp(5'd1, 1'b1, 1'b1, 32'hFEED_0001, 1'b0, 2'd0, 32'd0);
    applyStimulus(1'b1, 32'hFEED_0001, 32'd0, 3'd0, 5'd1, 1'b0, 1'b0, 1'b1);
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
